// File: rtl/traffic_pkg.sv
// Shared types, lamp encodings and default timing for the traffic phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_NS_G  = 3'd1,
    ST_NS_Y  = 3'd2,
    ST_AR1   = 3'd3,
    ST_EW_G  = 3'd4,
    ST_EW_Y  = 3'd5,
    ST_AR2   = 3'd6,
    ST_FLASH = 3'd7
  } state_e;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  localparam int DEF_MIN_GREEN = 10;
  localparam int DEF_MAX_GREEN = 30;
  localparam int DEF_GAP       = 3;
  localparam int DEF_YELLOW    = 3;
  localparam int DEF_ALL_RED   = 2;
  localparam int DEF_WALK      = 7;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  // True when one more tick brings cnt up to lim (9-bit compare avoids wrap).
  function automatic logic reached(input logic [7:0] cnt, input logic [7:0] lim);
    return ({1'b0, cnt} + 9'd1) >= {1'b0, lim};
  endfunction

endpackage

// File: rtl/tl_call_latch.sv
// Per-axis call and pedestrian-pending latches; a set always beats a same-cycle clear.
module tl_call_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic i_det,
  input  logic i_ped,
  input  logic i_clr,
  output logic o_call,
  output logic o_ped_pend
);

  logic r_call;
  logic r_ped_pend;

  // Latch state: set on request, clear on green entry, set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_call     <= 1'b0;
      r_ped_pend <= 1'b0;
    end else begin
      r_call     <= i_det | i_ped | (r_call & ~i_clr);
      r_ped_pend <= i_ped | (r_ped_pend & ~i_clr);
    end
  end

  assign o_call     = r_call;
  assign o_ped_pend = r_ped_pend;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-axis actuated intersection controller with gap-out, max-out, walk and fault flash.
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = traffic_pkg::DEF_MIN_GREEN,
  parameter int MAX_GREEN = traffic_pkg::DEF_MAX_GREEN,
  parameter int GAP       = traffic_pkg::DEF_GAP,
  parameter int YELLOW    = traffic_pkg::DEF_YELLOW,
  parameter int ALL_RED   = traffic_pkg::DEF_ALL_RED,
  parameter int WALK      = traffic_pkg::DEF_WALK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       det_ns,
  input  logic       det_ew,
  input  logic       ped_ns,
  input  logic       ped_ew,
  input  logic       flash_en,
  output logic [2:0] light_N,
  output logic [2:0] light_S,
  output logic [2:0] light_E,
  output logic [2:0] light_W,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [2:0] phase
);

  import traffic_pkg::*;

  localparam logic [7:0] C_MIN_GREEN = 8'(MIN_GREEN);
  localparam logic [7:0] C_MAX_GREEN = 8'(MAX_GREEN);
  localparam logic [7:0] C_GAP       = 8'(GAP);
  localparam logic [7:0] C_YELLOW    = 8'(YELLOW);
  localparam logic [7:0] C_ALL_RED   = 8'(ALL_RED);
  localparam logic [7:0] C_WALK      = 8'(WALK);

  state_e     r_state;
  logic [7:0] r_t_cnt;
  logic [7:0] r_g_cnt;
  logic [7:0] r_gap_cnt;
  logic [7:0] r_walk_cnt;
  logic       r_walk_ns;
  logic       r_walk_ew;
  logic       r_flash_on;
  logic [2:0] r_lamp_ns;
  logic [2:0] r_lamp_ew;

  state_e     w_state_nxt;
  logic [7:0] w_t_cnt_nxt;
  logic [7:0] w_g_cnt_nxt;
  logic [7:0] w_gap_cnt_nxt;
  logic [7:0] w_walk_cnt_nxt;
  logic       w_walk_ns_nxt;
  logic       w_walk_ew_nxt;
  logic       w_flash_on_nxt;
  logic [2:0] w_lamp_ns_nxt;
  logic [2:0] w_lamp_ew_nxt;

  logic       w_call_ns;
  logic       w_call_ew;
  logic       w_ped_pend_ns;
  logic       w_ped_pend_ew;
  logic       w_clr_ns;
  logic       w_clr_ew;
  logic       w_own_det;
  logic       w_opp_call;
  logic       w_walk_any;
  logic       w_gap_ok;
  logic [7:0] w_t_lim;

  assign w_clr_ns   = (w_state_nxt == ST_NS_G) && (r_state != ST_NS_G);
  assign w_clr_ew   = (w_state_nxt == ST_EW_G) && (r_state != ST_EW_G);
  assign w_own_det  = (r_state == ST_EW_G) ? det_ew : det_ns;
  assign w_opp_call = (r_state == ST_EW_G) ? w_call_ns : w_call_ew;
  assign w_walk_any = r_walk_ns | r_walk_ew;
  assign w_t_lim    = ((r_state == ST_NS_Y) || (r_state == ST_EW_Y)) ? C_YELLOW : C_ALL_RED;

  tl_call_latch u_latch_ns (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_det      (det_ns),
    .i_ped      (ped_ns),
    .i_clr      (w_clr_ns),
    .o_call     (w_call_ns),
    .o_ped_pend (w_ped_pend_ns)
  );

  tl_call_latch u_latch_ew (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_det      (det_ew),
    .i_ped      (ped_ew),
    .i_clr      (w_clr_ew),
    .o_call     (w_call_ew),
    .o_ped_pend (w_ped_pend_ew)
  );

  // Next-state, counter and lamp computation.
  always_comb begin
    w_state_nxt    = r_state;
    w_t_cnt_nxt    = r_t_cnt;
    w_g_cnt_nxt    = r_g_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_walk_cnt_nxt = r_walk_cnt;
    w_walk_ns_nxt  = r_walk_ns;
    w_walk_ew_nxt  = r_walk_ew;
    w_flash_on_nxt = r_flash_on;
    w_lamp_ns_nxt  = LAMP_RED;
    w_lamp_ew_nxt  = LAMP_RED;
    w_gap_ok       = 1'b0;

    case (r_state)
      ST_INIT, ST_NS_Y, ST_AR1, ST_EW_Y, ST_AR2: begin
        if (tick && reached(r_t_cnt, w_t_lim)) begin
          case (r_state)
            ST_INIT: w_state_nxt = ST_NS_G;
            ST_NS_Y: w_state_nxt = ST_AR1;
            ST_AR1:  w_state_nxt = ST_EW_G;
            ST_EW_Y: w_state_nxt = ST_AR2;
            default: w_state_nxt = ST_NS_G;
          endcase
        end else if (tick) begin
          w_t_cnt_nxt = r_t_cnt + 8'd1;
        end else begin
          w_t_cnt_nxt = r_t_cnt;
        end
      end
      ST_NS_G, ST_EW_G: begin
        if (tick) begin
          w_g_cnt_nxt = sat_inc(r_g_cnt, C_MAX_GREEN);
        end else begin
          w_g_cnt_nxt = r_g_cnt;
        end
        // A detection wins over a coincident tick: gap restarts from zero.
        if (w_own_det) begin
          w_gap_cnt_nxt = 8'd0;
        end else if (tick) begin
          w_gap_cnt_nxt = sat_inc(r_gap_cnt, C_GAP);
        end else begin
          w_gap_cnt_nxt = r_gap_cnt;
        end
        if (tick && w_walk_any && reached(r_walk_cnt, C_WALK)) begin
          w_walk_ns_nxt  = 1'b0;
          w_walk_ew_nxt  = 1'b0;
          w_walk_cnt_nxt = 8'd0;
        end else if (tick && w_walk_any) begin
          w_walk_cnt_nxt = r_walk_cnt + 8'd1;
        end else begin
          w_walk_cnt_nxt = r_walk_cnt;
        end
        w_gap_ok = (w_g_cnt_nxt >= C_MIN_GREEN) && (w_gap_cnt_nxt >= C_GAP);
        if (tick && w_opp_call && !(w_walk_ns_nxt | w_walk_ew_nxt) &&
            (w_gap_ok || (w_g_cnt_nxt >= C_MAX_GREEN))) begin
          w_state_nxt = (r_state == ST_NS_G) ? ST_NS_Y : ST_EW_Y;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_FLASH: begin
        if (tick) begin
          w_flash_on_nxt = ~r_flash_on;
        end else begin
          w_flash_on_nxt = r_flash_on;
        end
        if (!flash_en) begin
          w_state_nxt = ST_INIT;
        end else begin
          w_state_nxt = ST_FLASH;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase

    if (flash_en) begin
      w_state_nxt = ST_FLASH;
    end else begin
      w_state_nxt = w_state_nxt;
    end

    // State entry: restart all timers; a pedestrian press this very cycle still earns a walk.
    if (w_state_nxt != r_state) begin
      w_t_cnt_nxt    = 8'd0;
      w_g_cnt_nxt    = 8'd0;
      w_gap_cnt_nxt  = 8'd0;
      w_walk_cnt_nxt = 8'd0;
      w_walk_ns_nxt  = (w_state_nxt == ST_NS_G) && (w_ped_pend_ns | ped_ns);
      w_walk_ew_nxt  = (w_state_nxt == ST_EW_G) && (w_ped_pend_ew | ped_ew);
      w_flash_on_nxt = 1'b1;
    end else begin
      w_flash_on_nxt = w_flash_on_nxt;
    end

    case (w_state_nxt)
      ST_NS_G: w_lamp_ns_nxt = LAMP_GREEN;
      ST_NS_Y: w_lamp_ns_nxt = LAMP_YELLOW;
      ST_EW_G: w_lamp_ew_nxt = LAMP_GREEN;
      ST_EW_Y: w_lamp_ew_nxt = LAMP_YELLOW;
      ST_FLASH: begin
        w_lamp_ns_nxt = w_flash_on_nxt ? LAMP_YELLOW : LAMP_OFF;
        w_lamp_ew_nxt = w_flash_on_nxt ? LAMP_YELLOW : LAMP_OFF;
      end
      default: begin
        w_lamp_ns_nxt = LAMP_RED;
        w_lamp_ew_nxt = LAMP_RED;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_t_cnt    <= 8'd0;
      r_g_cnt    <= 8'd0;
      r_gap_cnt  <= 8'd0;
      r_walk_cnt <= 8'd0;
      r_walk_ns  <= 1'b0;
      r_walk_ew  <= 1'b0;
      r_flash_on <= 1'b0;
      r_lamp_ns  <= LAMP_RED;
      r_lamp_ew  <= LAMP_RED;
    end else begin
      r_state    <= w_state_nxt;
      r_t_cnt    <= w_t_cnt_nxt;
      r_g_cnt    <= w_g_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_walk_cnt <= w_walk_cnt_nxt;
      r_walk_ns  <= w_walk_ns_nxt;
      r_walk_ew  <= w_walk_ew_nxt;
      r_flash_on <= w_flash_on_nxt;
      r_lamp_ns  <= w_lamp_ns_nxt;
      r_lamp_ew  <= w_lamp_ew_nxt;
    end
  end

  assign light_N = r_lamp_ns;
  assign light_S = r_lamp_ns;
  assign light_E = r_lamp_ew;
  assign light_W = r_lamp_ew;
  assign walk_ns = r_walk_ns;
  assign walk_ew = r_walk_ew;
  assign phase   = r_state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Table-driven scenario bench for traffic_phase_scheduler with default timing.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       det_ns = 1'b0;
  logic       det_ew = 1'b0;
  logic       ped_ns = 1'b0;
  logic       ped_ew = 1'b0;
  logic       flash_en = 1'b0;
  logic [2:0] light_N, light_S, light_E, light_W;
  logic       walk_ns, walk_ew;
  logic [2:0] phase;

  traffic_phase_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .det_ns   (det_ns),
    .det_ew   (det_ew),
    .ped_ns   (ped_ns),
    .ped_ew   (ped_ew),
    .flash_en (flash_en),
    .light_N  (light_N),
    .light_S  (light_S),
    .light_E  (light_E),
    .light_W  (light_W),
    .walk_ns  (walk_ns),
    .walk_ew  (walk_ew),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  // Input bits {tick, det_ns, det_ew, ped_ns, ped_ew, flash_en}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] T    = 6'b100000;
  localparam logic [5:0] DN   = 6'b010000;
  localparam logic [5:0] DE   = 6'b001000;
  localparam logic [5:0] PN   = 6'b000100;
  localparam logic [5:0] PE   = 6'b000010;
  localparam logic [5:0] FL   = 6'b000001;

  localparam logic [2:0] P_INIT = 3'd0, P_NSG = 3'd1, P_NSY = 3'd2, P_AR1 = 3'd3;
  localparam logic [2:0] P_EWG  = 3'd4, P_EWY = 3'd5, P_AR2 = 3'd6, P_FL  = 3'd7;
  localparam logic [2:0] R = 3'b100, G = 3'b010, Y = 3'b001, O = 3'b000;
  localparam logic [1:0] W0 = 2'b00, WN = 2'b10, WE = 2'b01;

  typedef struct {
    logic [5:0]  in;
    int          rep;
    logic [16:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [16:0] sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [16:0] pk(input logic [2:0] ph, input logic [2:0] ln,
                                     input logic [2:0] le, input logic [1:0] w);
    return {ph, ln, ln, le, le, w};
  endfunction

  function automatic vec_t v(input logic [5:0] in, input int rep, input logic [2:0] ph,
                             input logic [2:0] ln, input logic [2:0] le, input logic [1:0] w);
    vec_t r;
    r.in  = in;
    r.rep = rep;
    r.exp = pk(ph, ln, le, w);
    return r;
  endfunction

  function automatic logic [16:0] observed();
    return {phase, light_N, light_S, light_E, light_W, walk_ns, walk_ew};
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ph=%0d lamps N%b S%b E%b W%b walk=%b, expected ph=%0d lamps N%b S%b E%b W%b walk=%b",
               name, got[16:14], got[13:11], got[10:8], got[7:5], got[4:2], got[1:0],
               exp[16:14], exp[13:11], exp[10:8], exp[7:5], exp[4:2], exp[1:0]);
    end
  endtask

  task automatic apply(input vec_t vv, input string name);
    logic [16:0] e;
    for (int r = 0; r < vv.rep; r++) begin
      @(negedge clk);
      {tick, det_ns, det_ew, ped_ns, ped_ew, flash_en} = vv.in;
      if (r == vv.rep - 1) sb.push_back(vv.exp);
      @(posedge clk);
    end
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check(name, observed(), e);
    end
  endtask

  initial begin
    // Power-up through first cycle of both axes, max-out under continuous demand.
    tbl.push_back(v(NONE,    5,  P_INIT, R, R, W0));
    tbl.push_back(v(T,       1,  P_INIT, R, R, W0));
    tbl.push_back(v(T,       1,  P_NSG,  G, R, W0));
    tbl.push_back(v(T,       100, P_NSG, G, R, W0));
    tbl.push_back(v(DE,      1,  P_NSG,  G, R, W0));
    tbl.push_back(v(T,       1,  P_NSY,  Y, R, W0));
    tbl.push_back(v(T,       2,  P_NSY,  Y, R, W0));
    tbl.push_back(v(T,       1,  P_AR1,  R, R, W0));
    tbl.push_back(v(T,       1,  P_AR1,  R, R, W0));
    tbl.push_back(v(T,       1,  P_EWG,  R, G, W0));
    tbl.push_back(v(DN | DE, 1,  P_EWG,  R, G, W0));
    tbl.push_back(v(T | DE,  29, P_EWG,  R, G, W0));
    tbl.push_back(v(T | DE,  1,  P_EWY,  R, Y, W0));
    tbl.push_back(v(T,       2,  P_EWY,  R, Y, W0));
    tbl.push_back(v(T,       1,  P_AR2,  R, R, W0));
    tbl.push_back(v(T,       1,  P_AR2,  R, R, W0));
    tbl.push_back(v(T,       1,  P_NSG,  G, R, W0));
    // Pedestrian on EW: walk 7 ticks, green held to minimum 10.
    tbl.push_back(v(PE,      1,  P_NSG,  G, R, W0));
    tbl.push_back(v(T,       9,  P_NSG,  G, R, W0));
    tbl.push_back(v(T,       1,  P_NSY,  Y, R, W0));
    tbl.push_back(v(T,       2,  P_NSY,  Y, R, W0));
    tbl.push_back(v(T,       2,  P_AR1,  R, R, W0));
    tbl.push_back(v(T,       1,  P_EWG,  R, G, WE));
    tbl.push_back(v(DN,      1,  P_EWG,  R, G, WE));
    tbl.push_back(v(T,       6,  P_EWG,  R, G, WE));
    tbl.push_back(v(T,       1,  P_EWG,  R, G, W0));
    tbl.push_back(v(T,       2,  P_EWG,  R, G, W0));
    tbl.push_back(v(T,       1,  P_EWY,  R, Y, W0));
    tbl.push_back(v(T,       2,  P_EWY,  R, Y, W0));
    tbl.push_back(v(T,       2,  P_AR2,  R, R, W0));
    tbl.push_back(v(T,       1,  P_NSG,  G, R, W0));
    // Flash during EW_Y; call latched in flash gaps out the next NS green.
    tbl.push_back(v(DE,      1,  P_NSG,  G, R, W0));
    tbl.push_back(v(T,       9,  P_NSG,  G, R, W0));
    tbl.push_back(v(T,       1,  P_NSY,  Y, R, W0));
    tbl.push_back(v(T,       2,  P_NSY,  Y, R, W0));
    tbl.push_back(v(T,       2,  P_AR1,  R, R, W0));
    tbl.push_back(v(T,       1,  P_EWG,  R, G, W0));
    tbl.push_back(v(DN,      1,  P_EWG,  R, G, W0));
    tbl.push_back(v(T,       9,  P_EWG,  R, G, W0));
    tbl.push_back(v(T,       1,  P_EWY,  R, Y, W0));
    tbl.push_back(v(FL,      1,  P_FL,   Y, Y, W0));
    tbl.push_back(v(T | FL,  1,  P_FL,   O, O, W0));
    tbl.push_back(v(DE | FL, 1,  P_FL,   O, O, W0));
    tbl.push_back(v(T | FL,  1,  P_FL,   Y, Y, W0));
    tbl.push_back(v(NONE,    1,  P_INIT, R, R, W0));
    tbl.push_back(v(T,       1,  P_INIT, R, R, W0));
    tbl.push_back(v(T,       1,  P_NSG,  G, R, W0));
    tbl.push_back(v(T,       9,  P_NSG,  G, R, W0));
    tbl.push_back(v(T,       1,  P_NSY,  Y, R, W0));
    // ped_ns coincident with NS_G entry: walk now and again next NS green.
    tbl.push_back(v(T,       2,  P_NSY,  Y, R, W0));
    tbl.push_back(v(T,       2,  P_AR1,  R, R, W0));
    tbl.push_back(v(T,       1,  P_EWG,  R, G, W0));
    tbl.push_back(v(DN,      1,  P_EWG,  R, G, W0));
    tbl.push_back(v(T,       9,  P_EWG,  R, G, W0));
    tbl.push_back(v(T,       3,  P_EWY,  R, Y, W0));
    tbl.push_back(v(T,       2,  P_AR2,  R, R, W0));
    tbl.push_back(v(T | PN,  1,  P_NSG,  G, R, WN));
    tbl.push_back(v(T,       6,  P_NSG,  G, R, WN));
    tbl.push_back(v(T,       1,  P_NSG,  G, R, W0));
    tbl.push_back(v(DE,      1,  P_NSG,  G, R, W0));
    tbl.push_back(v(T,       2,  P_NSG,  G, R, W0));
    tbl.push_back(v(T,       1,  P_NSY,  Y, R, W0));
    tbl.push_back(v(T,       2,  P_NSY,  Y, R, W0));
    tbl.push_back(v(T,       2,  P_AR1,  R, R, W0));
    tbl.push_back(v(T,       1,  P_EWG,  R, G, W0));
    tbl.push_back(v(T,       9,  P_EWG,  R, G, W0));
    tbl.push_back(v(T,       3,  P_EWY,  R, Y, W0));
    tbl.push_back(v(T,       2,  P_AR2,  R, R, W0));
    tbl.push_back(v(T,       1,  P_NSG,  G, R, WN));
    // Detection coincident with tick restarts the gap without counting that tick.
    tbl.push_back(v(T,       6,  P_NSG,  G, R, WN));
    tbl.push_back(v(T,       1,  P_NSG,  G, R, W0));
    tbl.push_back(v(DE,      1,  P_NSG,  G, R, W0));
    tbl.push_back(v(T | DN,  3,  P_NSG,  G, R, W0));
    tbl.push_back(v(T,       2,  P_NSG,  G, R, W0));
    tbl.push_back(v(T,       1,  P_NSY,  Y, R, W0));

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", observed(), pk(P_INIT, R, R, W0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("step%0d", i));
    end

    // Asynchronous reset mid-yellow, away from any clock edge.
    @(negedge clk);
    {tick, det_ns, det_ew, ped_ns, ped_ew, flash_en} = NONE;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", observed(), pk(P_INIT, R, R, W0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(v(T,    1, P_INIT, R, R, W0), "post_reset_tick1");
    apply(v(T,    1, P_NSG,  G, R, W0), "post_reset_tick2");
    apply(v(FL,   1, P_FL,   Y, Y, W0), "flash_from_green");
    apply(v(NONE, 1, P_INIT, R, R, W0), "flash_release");

    @(negedge clk);
    {tick, det_ns, det_ew, ped_ns, ped_ew, flash_en} = NONE;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
